// File: rtl/reg_xfer_ctrl_if.sv
// Request/acknowledge and register-enable bundle for the register transfer controller.
// The master side is the requester pair, and the slave side is the controller.
interface reg_xfer_ctrl_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
);
  logic            req0;
  logic [AW-1:0]   src0;
  logic [AW-1:0]   dst0;
  logic            req1;
  logic [AW-1:0]   src1;
  logic [AW-1:0]   dst1;
  logic            ack0;
  logic            ack1;
  logic [NREG-1:0] en_read;
  logic [NREG-1:0] en_write;
  logic            busy;
  logic            err;

  modport master (
    output req0, src0, dst0, req1, src1, dst1,
    input  ack0, ack1, en_read, en_write, busy, err
  );

  modport slave (
    input  req0, src0, dst0, req1, src1, dst1,
    output ack0, ack1, en_read, en_write, busy, err
  );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Moves one register to another over a shared tri-state bus by sequencing the registers'
// EnRead/EnWrite strobes. Two requesters are served round-robin. All outputs are registered.
module reg_xfer_ctrl #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_xfer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StAck} state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;     // requester being served
  logic            last_q, last_d;   // requester served most recently
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [NREG-1:0] en_read_q, en_read_d;
  logic [NREG-1:0] en_write_q, en_write_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  // Out-of-range indices decode to an all-zero vector.
  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] idx);
    logic [NREG-1:0] vec;
    vec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(idx) == i) vec[i] = 1'b1;
    end
    return vec;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] idx);
    return 32'(idx) < NREG;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    src_d   = src_q;
    dst_d   = dst_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          last_d  = gnt_d;
          src_d   = gnt_d ? bus.src1 : bus.src0;
          dst_d   = gnt_d ? bus.dst1 : bus.dst0;
          state_d = StRead;
        end
      end
      StRead:  state_d = StWrite;
      StWrite: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state so that they line up with it once registered.
    en_read_d  = '0;
    en_write_d = '0;
    if (state_d == StRead || state_d == StWrite) en_read_d = decode(src_d);
    if (state_d == StWrite) en_write_d = decode(dst_d);
    ack0_d = (state_d == StAck) && !gnt_d;
    ack1_d = (state_d == StAck) && gnt_d;
    err_d  = (state_d == StAck) && !(in_range(src_d) && in_range(dst_d));
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      src_q      <= '0;
      dst_q      <= '0;
      en_read_q  <= '0;
      en_write_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      en_read_q  <= en_read_d;
      en_write_q <= en_write_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.en_read  = en_read_q;
  assign bus.en_write = en_write_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: an 8-register instance with a behavioural register
// bank on the bus, plus a 6-register instance for out-of-range indices.
module tb_reg_xfer_ctrl;

  logic clk;
  logic rst_n;
  int   cmp_cnt = 0;
  int   mis_cnt = 0;

  reg_xfer_ctrl_if #(.NREG(8), .AW(3)) b8 ();
  reg_xfer_ctrl_if #(.NREG(6), .AW(3)) b6 ();

  reg_xfer_ctrl #(.NREG(8), .AW(3)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  reg_xfer_ctrl #(.NREG(6), .AW(3)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: drives the bus from the enabled reader, captures on the falling edge.
  logic [19:0] regs [8] = '{20'h0, 20'h0, 20'hABCDE, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
  logic [19:0] bus_data;

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (b8.en_read[i]) bus_data = regs[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (b8.en_write[i]) regs[i] <= bus_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    b8.req0 = 1'b0; b8.src0 = '0; b8.dst0 = '0;
    b8.req1 = 1'b0; b8.src1 = '0; b8.dst1 = '0;
    b6.req0 = 1'b0; b6.src0 = '0; b6.dst0 = '0;
    b6.req1 = 1'b0; b6.src1 = '0; b6.dst1 = '0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_en_read",  b8.en_read,  8'h00);
    chk("rst_en_write", b8.en_write, 8'h00);
    chk("rst_ack0",     b8.ack0,     1'b0);
    chk("rst_ack1",     b8.ack1,     1'b0);
    chk("rst_busy",     b8.busy,     1'b0);
    chk("rst_err",      b8.err,      1'b0);
    chk("rst_busy6",    b6.busy,     1'b0);

    // Single transfer reg2 -> reg5, with src0/dst0 changed after grant
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b8.req0 = 1'b1; b8.src0 = 3'd2; b8.dst0 = 3'd5;
    tick();
    chk("rd_busy",     b8.busy,     1'b1);
    chk("rd_en_read",  b8.en_read,  8'h04);
    chk("rd_en_write", b8.en_write, 8'h00);
    b8.src0 = 3'd7; b8.dst0 = 3'd3;
    tick();
    chk("wr_en_read",  b8.en_read,  8'h04);
    chk("wr_en_write", b8.en_write, 8'h20);
    tick();
    chk("ack_ack0",     b8.ack0,    1'b1);
    chk("ack_ack1",     b8.ack1,    1'b0);
    chk("ack_en_read",  b8.en_read, 8'h00);
    chk("ack_err",      b8.err,     1'b0);
    chk("reg5_data",    regs[5],    20'hABCDE);
    chk("reg3_intact",  regs[3],    20'h00000);
    b8.req0 = 1'b0;
    tick();
    chk("idle_busy", b8.busy, 1'b0);
    chk("idle_ack0", b8.ack0, 1'b0);

    // Contention from reset: grants alternate 0,1,0,1, one transfer every 4 cycles
    rst_n = 1'b0;
    #1;
    b8.req0 = 1'b1; b8.src0 = 3'd1; b8.dst0 = 3'd2;
    b8.req1 = 1'b1; b8.src1 = 3'd3; b8.dst1 = 3'd4;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_en_read", k), b8.en_read, (k % 2 == 0) ? 8'h02 : 8'h08);
      tick();
      tick();
      chk($sformatf("rr%0d_ack0", k), b8.ack0, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_ack1", k), b8.ack1, (k % 2 == 0) ? 1'b0 : 1'b1);
      tick();
    end

    // Requester 0 served last, then reset in WRITE: requester 0 still wins afterwards
    b8.req1 = 1'b0;
    tick();
    tick();
    chk("pre_rst_en_write", b8.en_write, 8'h04);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_en_read",  b8.en_read,  8'h00);
    chk("rstw_en_write", b8.en_write, 8'h00);
    chk("rstw_busy",     b8.busy,     1'b0);
    chk("rstw_ack0",     b8.ack0,     1'b0);
    b8.req1 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_ack0", b8.ack0, 1'b1);
    chk("post_rst_ack1", b8.ack1, 1'b0);
    b8.req0 = 1'b0; b8.req1 = 1'b0;
    tick();

    // Out-of-range source on the 6-register instance
    b6.req1 = 1'b1; b6.src1 = 3'd7; b6.dst1 = 3'd1;
    tick();
    chk("oor_rd_en_read", b6.en_read, 6'h00);
    chk("oor_rd_busy",    b6.busy,    1'b1);
    b6.req1 = 1'b0;
    tick();
    chk("oor_wr_en_read",  b6.en_read,  6'h00);
    chk("oor_wr_en_write", b6.en_write, 6'h02);
    tick();
    chk("oor_ack1", b6.ack1, 1'b1);
    chk("oor_err",  b6.err,  1'b1);
    chk("oor_ack0", b6.ack0, 1'b0);
    tick();
    chk("oor_err_clr",  b6.err,  1'b0);
    chk("oor_ack1_clr", b6.ack1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
